skolem_solve_sched: RTL and testbench
=====================================

SKOLEM_SOLVE_SCHED -- requirements
Module: skolem_solve_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the completed-request counter.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  requester 0 has a query pending.
REQ-006 req0_s  input  WIDTH  requester 0 addend s.
REQ-007 req0_t  input  WIDTH  requester 0 target sum t.
REQ-008 req0_ready  output  1  query 0 accepted this cycle when high with req0_valid.
REQ-009 req1_valid, req1_s, req1_t, req1_ready  same directions/widths/meaning as requester 0.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  1  index of requester the result belongs to.
REQ-013 rsp_x  output  WIDTH  solution x with (x + s) mod 2^WIDTH == t.
REQ-014 rsp_ok  output  1  self-check passed for rsp_x.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done_cnt  output  CNT_W  count of responses handed off, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, SOLVE, CHECK, RESP; one query in flight at a time.
REQ-018 IDLE: SHALL assert reqN_ready only for the arbitration winner, combinationally from the valid inputs; both readys low outside IDLE.
REQ-019 Arbitration SHALL be round-robin: one valid -> that requester wins; both valid -> requester other than last_grant wins; last_grant resets to 1, so req0 wins first contention.
REQ-020 On handshake, SHALL latch s, t, id, update last_grant, clear borrow and bit index, go to SOLVE.
REQ-021 SOLVE: SHALL compute one bit per cycle LSB first, x_i = t_i ^ s_i ^ b, b_next = (~t_i & s_i) | (~(t_i ^ s_i) & b); exactly WIDTH cycles, then CHECK.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; final borrow discarded; every (s, t) pair has a solution.
REQ-023 CHECK: one cycle; SHALL compute (x + s) mod 2^WIDTH with a full-width adder, set ok = (sum == t), go to RESP.
REQ-024 RESP: rsp_valid high; rsp_id, rsp_x, rsp_ok stable until rsp_valid & rsp_ready.
REQ-025 On response handshake SHALL return to IDLE and increment done_cnt, holding at 2^CNT_W-1.
REQ-026 Latency: handshake at edge k -> rsp_valid high in the cycle after edge k+WIDTH+1 (WIDTH+2 edges); new query acceptable the cycle after response handshake; no back-to-back overlap.
REQ-027 Input changes on reqN_s/t after acceptance SHALL NOT affect the in-flight result.
REQ-028 rsp_valid low in IDLE, SOLVE, CHECK; rsp_x, rsp_id, rsp_ok hold last value when rsp_valid low.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, rsp_valid 0, rsp_x 0, rsp_id 0, rsp_ok 0, busy 0, done_cnt 0, last_grant 1, borrow 0, bit index 0, with readys then following REQ-018.
REQ-030 Reset mid-SOLVE/CHECK/RESP SHALL abandon the query without a response; first post-reset acceptance needs rst_n high at a clock edge.

Verification
REQ-031 WIDTH=4, req0 s=3 t=1, rsp_ready=1 -> rsp_valid 6 edges after handshake, rsp_x=14, rsp_id=0, rsp_ok=1, done_cnt=1.
REQ-032 req0 s=0 t=0 then req1 s=15 t=0 -> rsp_x=0 then rsp_x=1, ids 0 then 1, ok=1 both.
REQ-033 Both valid continuously from reset, 4 queries -> grant/rsp_id order 0,1,0,1; never both readys high.
REQ-034 rsp_ready low 10 cycles in RESP -> rsp_valid, rsp_x, rsp_id stable, both readys low, done_cnt unchanged until handshake.
REQ-035 rst_n pulsed low during SOLVE bit 2 -> outputs at reset values same cycle, no response emitted, next query (s=5 t=2 -> x=13) completes normally.
REQ-036 Exhaustive 256 (s,t) pairs at WIDTH=4 random requester and backpressure -> every rsp_x == (t-s) mod 16, rsp_ok=1; done_cnt saturates at 255.

Source files
------------

// File: rtl/skolem_solve_sched.sv
// Bit-serial solver for x in (x + s) mod 2^WIDTH == t, serving two requesters
// with round-robin arbitration, one query in flight, and a full-width self-check.
module skolem_solve_sched #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_s,
  input  logic [WIDTH-1:0] req0_t,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_s,
  input  logic [WIDTH-1:0] req1_t,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_x,
  output logic             rsp_ok,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SOLVE, CHECK, RESP} state_t;

  state_t             state;
  logic               last_grant;
  logic               borrow;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   s_q, t_q, x_q;
  logic               id_q;

  logic               grant_any;
  logic               grant_id;
  logic [WIDTH-1:0]   sel_s, sel_t;
  logic [WIDTH-1:0]   chk_sum;
  logic               s_bit, t_bit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else if (req1_valid)          grant_id = 1'b1;
    sel_s   = grant_id ? req1_s : req0_s;
    sel_t   = grant_id ? req1_t : req0_t;
    s_bit   = s_q[idx];
    t_bit   = t_q[idx];
    chk_sum = x_q + s_q;
  end

  // Readys are a pure function of IDLE and the valids so the winner sees acceptance in-cycle.
  assign req0_ready = (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = (state == IDLE) && grant_any &&  grant_id;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      borrow     <= 1'b0;
      idx        <= '0;
      s_q        <= '0;
      t_q        <= '0;
      x_q        <= '0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_x      <= '0;
      rsp_ok     <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            s_q        <= sel_s;
            t_q        <= sel_t;
            id_q       <= grant_id;
            last_grant <= grant_id;
            borrow     <= 1'b0;
            idx        <= '0;
            state      <= SOLVE;
          end
        end
        SOLVE: begin
          // Borrow-propagating subtract t - s, one bit per cycle from the LSB.
          x_q[idx] <= t_bit ^ s_bit ^ borrow;
          borrow   <= (~t_bit & s_bit) | (~(t_bit ^ s_bit) & borrow);
          if (idx == LAST_IDX) state <= CHECK;
          else                 idx   <= idx + 1'b1;
        end
        CHECK: begin
          rsp_x  <= x_q;
          rsp_id <= id_q;
          rsp_ok <= (chk_sum == t_q);
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            if (done_cnt != '1) done_cnt <= done_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_solve_sched.sv
// Scoreboard bench for skolem_solve_sched (WIDTH=4): drivers push expected
// results at acceptance, an independent monitor pops and compares on handoff.
module tb_skolem_solve_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_s, req0_t, req1_s, req1_t;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ok, busy;
  logic [W-1:0] rsp_x;
  logic [7:0]   done_cnt;

  logic         bp_en, bp_rand, rsp_ready_man;
  assign rsp_ready = bp_en ? bp_rand : rsp_ready_man;

  skolem_solve_sched #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_s(req0_s), .req0_t(req0_t), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_s(req1_s), .req1_t(req1_t), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_x(rsp_x),
    .rsp_ok(rsp_ok), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] x;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   model_cnt = 0;
  int   both_err = 0;
  int   busy_err = 0;
  bit   grant_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    bp_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1 bp_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: owns the scoreboard pop, the handoff counter model and protocol counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      model_cnt = 0;
    end else begin
      if (req0_ready && req1_ready)        both_err++;
      if (busy && (req0_ready || req1_ready)) busy_err++;
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got id=%0d x=%0d expected no response", rsp_id, rsp_x);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_x", rsp_x, e.x);
          check("rsp_ok", rsp_ok, 1);
          check("done_cnt_pre", done_cnt, model_cnt);
          if (model_cnt < 255) model_cnt++;
        end
      end
    end
  end

  task automatic wait_accept(input bit r, input logic [W-1:0] s, input logic [W-1:0] t);
    int   n = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (!(r ? req1_ready : req0_ready) && n < 2000);
    if (r ? req1_ready : req0_ready) begin
      e.id = r;
      e.x  = t - s;
      q.push_back(e);
      hs_cyc = cyc;
      grant_log.push_back(r);
    end else begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no ready for req%0d expected acceptance", r);
    end
  endtask

  task automatic issue(input bit r, input logic [W-1:0] s, input logic [W-1:0] t);
    if (r) begin req1_valid = 1'b1; req1_s = s; req1_t = t; end
    else   begin req0_valid = 1'b1; req0_s = s; req0_t = t; end
    wait_accept(r, s, t);
    @(posedge clk);
    #1;
    if (r) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid(output int lat);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - hs_cyc;
    if (!rsp_valid) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_x"}, rsp_x, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_ok"}, rsp_ok, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done_cnt"}, done_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_s = '0; req0_t = '0; req1_s = '0; req1_t = '0;
    bp_en = 1'b0; rsp_ready_man = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single query: latency counted in edges including the handshake edge.
    issue(0, 4'd3, 4'd1);
    wait_rsp_valid(lat);
    check("latency_edges", lat, W + 2);
    drain();
    check("done_cnt_first", done_cnt, 1);

    // Zero operands, then wraparound 0 - 15 = 1 from the other requester.
    issue(0, 4'd0, 4'd0);
    issue(1, 4'd15, 4'd0);
    drain();

    // Continuous contention from reset: grants alternate starting with req0.
    do_reset();
    grant_log.delete();
    fork
      begin
        req0_valid = 1'b1; req0_s = 4'd1; req0_t = 4'd4;
        wait_accept(0, 4'd1, 4'd4);
        @(posedge clk); #1 req0_s = 4'd2; req0_t = 4'd9;
        wait_accept(0, 4'd2, 4'd9);
        @(posedge clk); #1 req0_valid = 1'b0;
      end
      begin
        req1_valid = 1'b1; req1_s = 4'd6; req1_t = 4'd6;
        wait_accept(1, 4'd6, 4'd6);
        @(posedge clk); #1 req1_s = 4'd10; req1_t = 4'd3;
        wait_accept(1, 4'd10, 4'd3);
        @(posedge clk); #1 req1_valid = 1'b0;
      end
    join
    drain();
    check("grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("grant0", grant_log[0], 0);
      check("grant1", grant_log[1], 1);
      check("grant2", grant_log[2], 0);
      check("grant3", grant_log[3], 1);
    end

    // Backpressure: response held while req1 waits, nothing accepted meanwhile.
    rsp_ready_man = 1'b0;
    issue(0, 4'd7, 4'd2);
    req1_valid = 1'b1; req1_s = 4'd1; req1_t = 4'd4;
    wait_rsp_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_x", rsp_x, 11);
      check("stall_rsp_id", rsp_id, 0);
      check("stall_req0_ready", req0_ready, 0);
      check("stall_req1_ready", req1_ready, 0);
      check("stall_done_cnt", done_cnt, 4);
    end
    @(posedge clk);
    #1 rsp_ready_man = 1'b1;
    wait_accept(1, 4'd1, 4'd4);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();
    check("done_cnt_after_stall", done_cnt, 6);

    // Reset while SOLVE works on bit 2: query abandoned, next one completes.
    issue(0, 4'd9, 4'd9);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midsolve");
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 4'd5, 4'd2);
    drain();
    check("done_cnt_post_reset", done_cnt, 1);

    // All 256 pairs with random requester and random backpressure.
    bp_en = 1'b1;
    for (int s = 0; s < 16; s++) begin
      for (int t = 0; t < 16; t++) begin
        issue(1'($urandom_range(0, 1)), 4'(s), 4'(t));
      end
    end
    drain();
    bp_en = 1'b0;
    check("done_cnt_saturated", done_cnt, 255);
    check("both_readys_high", both_err, 0);
    check("ready_while_busy", busy_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
